// File: rtl/pipe_startup_ctrl.sv
// Pipeline start-up sequencer: raises stage enables one by one from the fetch side, then reports ready.
// Optional restart support is compiled in with `define QU_STARTUP_RESTART_EN.
module pipe_startup_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int STAGE_GAP  = 1,
  parameter int INIT_WAIT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  restart_req,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  ready,
  output logic                  busy
);

  localparam int CNT_MAX = (INIT_WAIT > STAGE_GAP) ? INIT_WAIT : STAGE_GAP;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_RAMP,
    ST_RUN
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    clear_req;
  logic [NUM_STAGES-1:0]   en_shift;

`ifdef QU_STARTUP_RESTART_EN
  assign clear_req = rst | restart_req;
`else
  logic unused_restart_req;
  assign unused_restart_req = restart_req;
  assign clear_req          = rst;
`endif

  // Next enable pattern: one more stage switched on at the fetch end; its top bit marks the last stage.
  assign en_shift = (stage_en << 1) | NUM_STAGES'(1);

  always_ff @(posedge clk) begin
    if (clear_req) begin
      state    <= ST_WAIT;
      cnt      <= CNT_W'(INIT_WAIT);
      stage_en <= '0;
      ready    <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        ST_WAIT, ST_RAMP: begin
          if (!hold) begin
            if (cnt == '0) begin
              stage_en <= en_shift;
              if (en_shift[NUM_STAGES-1]) begin
                state <= ST_RUN;
                ready <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= ST_RAMP;
                cnt   <= CNT_W'(STAGE_GAP - 1);
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_WAIT;
        end
      endcase
    end
  end

endmodule
